// File: rtl/audio_pkg.sv
// Shared audio definitions: I2S frame geometry and the stereo sample pair type.
package audio_pkg;

    parameter int SAMPLE_W = 24;

    localparam int I2S_SLOTS     = 64;
    localparam int I2S_SLOT_BITS = 32;

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } stereo_sample_t;

endpackage

// File: rtl/i2s_clk_div.sv
// BCLK generator: divides i_clk by 2*BCLK_DIV and flags the cycle whose closing
// edge moves BCLK, so downstream registers change together with o_bclk.
module i2s_clk_div #(
    parameter int BCLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_bclk,
    output logic o_fall,
    output logic o_rise
);

    localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          bclk_q;
    logic          bclk_d;
    logic          term_s;

    // Divider next state: wrap and toggle BCLK at the terminal count.
    always_comb begin
        term_s = (cnt_q == CW'(BCLK_DIV - 1));
        cnt_d  = term_s ? '0 : cnt_q + CW'(1);
        bclk_d = term_s ? ~bclk_q : bclk_q;
    end

    // Divider and BCLK state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bclk_q <= bclk_d;
        end
    end

    assign o_bclk = bclk_q;
    assign o_fall = term_s & bclk_q;
    assign o_rise = term_s & ~bclk_q;

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S stereo transmitter: one-pair holding register, 64-slot frame, MSB-first shifter.
// Optional macro I2S_TX_UNDERFLOW_CNT_EN adds a saturating 16-bit o_underflow_cnt output.
module i2s_tx
    import audio_pkg::*;
#(
    parameter int WIDTH    = 24,
    parameter int BCLK_DIV = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_left,
    input  logic [WIDTH-1:0] i_right,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_bclk,
    output logic             o_lrclk,
    output logic             o_sdata,
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    output logic [15:0]      o_underflow_cnt,
`endif
    output logic             o_underflow
);

    localparam int SW = $clog2(I2S_SLOTS);

    typedef struct packed {
        logic [WIDTH-1:0] left;
        logic [WIDTH-1:0] right;
    } pair_t;

    // One channel as it appears on the wire: a zero slot, the sample MSB first, zero padding.
    function automatic logic [I2S_SLOT_BITS-1:0] slot_word(input logic [WIDTH-1:0] smp);
        logic [I2S_SLOT_BITS-1:0] w;
        w = '0;
        w[I2S_SLOT_BITS-2 -: WIDTH] = smp;
        return w;
    endfunction

    logic                 fall_s;
    logic                 unused_rise_s;
    logic                 accept_s;
    logic                 load_s;
    pair_t                hold_q, hold_d;
    logic                 full_q, full_d;
    logic [SW-1:0]        slot_q, slot_d;
    logic                 lrclk_q, lrclk_d;
    logic [I2S_SLOTS-1:0] shreg_q, shreg_d;
    logic                 uf_q, uf_d;

    i2s_clk_div #(
        .BCLK_DIV (BCLK_DIV)
    ) u_clk_div (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_bclk (o_bclk),
        .o_fall (fall_s),
        .o_rise (unused_rise_s)
    );

    // Handshake, slot sequencing and frame load/shift.
    always_comb begin
        hold_d   = hold_q;
        full_d   = full_q;
        slot_d   = slot_q;
        lrclk_d  = lrclk_q;
        shreg_d  = shreg_q;
        uf_d     = 1'b0;
        accept_s = i_valid & ~full_q;
        load_s   = fall_s & (slot_q == SW'(I2S_SLOTS - 1));

        if (accept_s) begin
            hold_d = '{left: i_left, right: i_right};
            full_d = 1'b1;
        end else begin
            hold_d = hold_q;
        end

        // A load only sees the holding register as it stood before this cycle's accept.
        if (fall_s) begin
            slot_d  = slot_q + SW'(1);
            lrclk_d = slot_d[SW-1];
            if (load_s) begin
                if (full_q) begin
                    shreg_d = {slot_word(hold_q.left), slot_word(hold_q.right)};
                    full_d  = 1'b0;
                end else begin
                    shreg_d = '0;
                    uf_d    = 1'b1;
                end
            end else begin
                shreg_d = {shreg_q[I2S_SLOTS-2:0], 1'b0};
            end
        end else begin
            slot_d = slot_q;
        end
    end

    // Transmitter state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_q  <= '0;
            full_q  <= 1'b0;
            slot_q  <= SW'(I2S_SLOTS - 1);
            lrclk_q <= 1'b0;
            shreg_q <= '0;
            uf_q    <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            full_q  <= full_d;
            slot_q  <= slot_d;
            lrclk_q <= lrclk_d;
            shreg_q <= shreg_d;
            uf_q    <= uf_d;
        end
    end

    assign o_ready     = ~full_q;
    assign o_lrclk     = lrclk_q;
    assign o_sdata     = shreg_q[I2S_SLOTS-1];
    assign o_underflow = uf_q;

`ifdef I2S_TX_UNDERFLOW_CNT_EN
    logic [15:0] ucnt_q;
    logic [15:0] ucnt_d;

    // Saturating underflow count, advanced together with the pulse.
    always_comb begin
        if (uf_d && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'd1;
        end else begin
            ucnt_d = ucnt_q;
        end
    end

    // Underflow count register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ucnt_q <= 16'd0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign o_underflow_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: two instances (BCLK_DIV 2 and 1) against a frame-level model.
`timescale 1ns/1ps
module tb_i2s_tx;

    localparam int W = 24;
    typedef logic [63:0] frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   rst_v;
    logic [1:0]   valid_v;
    logic [W-1:0] left_a  [2];
    logic [W-1:0] right_a [2];
    logic [1:0]   ready_v, bclk_v, lrclk_v, sdata_v, uf_v;
`ifdef I2S_TX_UNDERFLOW_CNT_EN
    logic [1:0][15:0] ucnt_v;
`endif

    i2s_tx #(.WIDTH(W), .BCLK_DIV(2)) u_dut0 (
        .i_clk(clk), .i_rst(rst_v[0]), .i_left(left_a[0]), .i_right(right_a[0]),
        .i_valid(valid_v[0]), .o_ready(ready_v[0]), .o_bclk(bclk_v[0]),
        .o_lrclk(lrclk_v[0]), .o_sdata(sdata_v[0]),
`ifdef I2S_TX_UNDERFLOW_CNT_EN
        .o_underflow_cnt(ucnt_v[0]),
`endif
        .o_underflow(uf_v[0])
    );

    i2s_tx #(.WIDTH(W), .BCLK_DIV(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst_v[1]), .i_left(left_a[1]), .i_right(right_a[1]),
        .i_valid(valid_v[1]), .o_ready(ready_v[1]), .o_bclk(bclk_v[1]),
        .o_lrclk(lrclk_v[1]), .o_sdata(sdata_v[1]),
`ifdef I2S_TX_UNDERFLOW_CNT_EN
        .o_underflow_cnt(ucnt_v[1]),
`endif
        .o_underflow(uf_v[1])
    );

    // ---------------- reference model state (written by the model process only) ----------
    int           m_cyc   [2];
    bit           m_full  [2];
    bit           m_uf    [2];
    bit           m_rst   [2];
    bit           m_acc   [2];
    int           m_ucnt  [2];
    logic [W-1:0] m_hl    [2];
    logic [W-1:0] m_hr    [2];
    frame_t       sb0[$];
    frame_t       sb1[$];

    int  n_tests = 0;
    int  n_fail  = 0;
    int  tmo     = 0;
    bit  end_req = 1'b0;
    bit  mon_done = 1'b0;

    function automatic int divof(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    // Wire image of a stereo pair: slot s of each half carries bit W-s of the sample.
    function automatic frame_t frame_of(input logic [W-1:0] l, input logic [W-1:0] r);
        frame_t f = '0;
        for (int s = 0; s < 64; s++) begin
            int pos = s % 32;
            logic [W-1:0] smp = (s < 32) ? l : r;
            if (pos >= 1 && pos <= W) f[63-s] = smp[W-pos];
        end
        return f;
    endfunction

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, d, $time, act, exp);
        end
    endtask

    // Model: frame loads fall every 128*DIV cycles starting 2*DIV cycles after release.
    initial forever begin
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            int dv;
            bit ready_old;
            frame_t f;
            dv = divof(d);
            if (rst_v[d]) begin
                m_cyc[d] = 0; m_full[d] = 1'b0; m_uf[d] = 1'b0; m_acc[d] = 1'b0;
                m_ucnt[d] = 0; m_rst[d] = 1'b1;
                if (d == 0) sb0.delete(); else sb1.delete();
            end else begin
                m_rst[d] = 1'b0; m_uf[d] = 1'b0; m_acc[d] = 1'b0;
                m_cyc[d]++;
                ready_old = !m_full[d];
                if (m_cyc[d] >= 2*dv && (m_cyc[d] - 2*dv) % (128*dv) == 0) begin
                    if (m_full[d]) begin
                        f = frame_of(m_hl[d], m_hr[d]);
                        m_full[d] = 1'b0;
                    end else begin
                        f = '0;
                        m_uf[d] = 1'b1;
                        if (m_ucnt[d] < 65535) m_ucnt[d]++;
                    end
                    if (d == 0) sb0.push_back(f); else sb1.push_back(f);
                end
                if (valid_v[d] && ready_old) begin
                    m_hl[d] = left_a[d]; m_hr[d] = right_a[d];
                    m_full[d] = 1'b1; m_acc[d] = 1'b1;
                end
            end
        end
    end

    // ---------------- monitor: samples SDATA/LRCLK on BCLK rising edges ----------------
    bit     pb    [2];
    int     nrise [2];
    int     nbits [2];
    frame_t dw    [2];
    frame_t lw    [2];

    initial forever begin
        @(negedge clk);
        if (end_req && !mon_done) begin
            chk("wait_timeouts", 0, 64'(tmo), 64'd0);
            mon_done = 1'b1;
        end
        for (int d = 0; d < 2; d++) begin
            int dv;
            frame_t ef;
            bit have;
            dv = divof(d);
            chk("ready", d, 64'(ready_v[d]), 64'(!m_full[d]));
            chk("underflow", d, 64'(uf_v[d]), 64'(m_uf[d]));
            chk("bclk", d, 64'(bclk_v[d]), 64'((m_cyc[d] / dv) % 2));
`ifdef I2S_TX_UNDERFLOW_CNT_EN
            chk("underflow_cnt", d, 64'(ucnt_v[d]), 64'(m_ucnt[d]));
`endif
            if (m_rst[d]) begin
                chk("rst_sdata", d, 64'(sdata_v[d]), 64'd0);
                chk("rst_lrclk", d, 64'(lrclk_v[d]), 64'd0);
                nrise[d] = 0; nbits[d] = 0; pb[d] = 1'b0;
            end else begin
                if (bclk_v[d] && !pb[d]) begin
                    if (nrise[d] > 0) begin
                        dw[d] = {dw[d][62:0], sdata_v[d]};
                        lw[d] = {lw[d][62:0], lrclk_v[d]};
                        nbits[d]++;
                        if (nbits[d] == 64) begin
                            nbits[d] = 0;
                            have = (d == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
                            chk("frame_avail", d, 64'(have), 64'd1);
                            if (have) begin
                                ef = (d == 0) ? sb0.pop_front() : sb1.pop_front();
                                chk("frame_sdata", d, dw[d], ef);
                                chk("frame_lrclk", d, lw[d], 64'h00000000_FFFFFFFF);
                            end
                        end
                    end
                    nrise[d]++;
                end
                pb[d] = bclk_v[d];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int d, input logic [W-1:0] l, input logic [W-1:0] r);
        int k = 0;
        valid_v[d] = 1'b1; left_a[d] = l; right_a[d] = r;
        do begin
            @(negedge clk);
            k++;
        end while (!m_acc[d] && k < 1000);
        if (!m_acc[d]) tmo++;
        valid_v[d] = 1'b0;
    endtask

    task automatic stream(input int d, input int n);
        int k = 0;
        int i = 0;
        valid_v[d] = 1'b1;
        left_a[d] = W'(24'h100000); right_a[d] = W'(24'hF00000);
        while (i < n && k < 700*n) begin
            @(negedge clk);
            k++;
            if (m_acc[d]) begin
                i++;
                left_a[d] = W'(24'h100000 + i); right_a[d] = W'(24'hF00000 - i);
            end
        end
        if (i < n) tmo++;
        valid_v[d] = 1'b0;
    endtask

    task automatic run(input int d);
        int dv = divof(d);
        int fr = 128*dv;
        int k;
        rst_v[d] = 1'b1; valid_v[d] = 1'b0;
        cyc_wait(3);
        rst_v[d] = 1'b0;
        if (d == 0) send(d, 24'hABCDEF, 24'h123456);
        else        send(d, 24'h7FFFFF, 24'h800000);
        cyc_wait(4*fr);
        stream(d, 4);
        cyc_wait(2*fr);
        k = 0;
        while (!(!m_full[d] && m_cyc[d] + 1 >= 2*dv && (m_cyc[d] + 1 - 2*dv) % fr == 0) && k < 4*fr) begin
            @(negedge clk);
            k++;
        end
        if (k >= 4*fr) tmo++;
        valid_v[d] = 1'b1; left_a[d] = 24'h5A5A5A; right_a[d] = 24'hA5A5A5;
        @(negedge clk);
        valid_v[d] = 1'b0;
        cyc_wait(2*fr + 8);
        for (int c = 0; c < 6*fr; c++) begin
            valid_v[d] = ($urandom_range(3) == 0);
            left_a[d] = W'($urandom); right_a[d] = W'($urandom);
            @(negedge clk);
        end
        valid_v[d] = 1'b0;
        cyc_wait(2*fr);
        send(d, 24'h13579B, 24'h2468AC);
        k = 0;
        while (!(m_cyc[d] >= 2*dv && ((m_cyc[d] - 2*dv) / (2*dv)) % 64 == 40 && !m_full[d]) && k < 4*fr) begin
            @(negedge clk);
            k++;
        end
        if (k >= 4*fr) tmo++;
        valid_v[d] = 1'b1; left_a[d] = 24'h0F0F0F; right_a[d] = 24'hF0F0F0;
        @(negedge clk);
        valid_v[d] = 1'b0;
        rst_v[d] = 1'b1;
        @(negedge clk);
        rst_v[d] = 1'b0;
        send(d, 24'hC0FFEE, 24'h0BEEF0);
        cyc_wait(3*fr);
    endtask

    initial begin
        int k;
        rst_v = 2'b11; valid_v = 2'b00;
        left_a[0] = '0; left_a[1] = '0; right_a[0] = '0; right_a[1] = '0;
        fork
            run(0);
            run(1);
        join
        end_req = 1'b1;
        k = 0;
        while (!mon_done && k < 10) begin
            @(negedge clk);
            k++;
        end
        if (!mon_done) $display("FAIL monitor_end: monitor did not finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Stereo I2S transmitter in the audio clock domain. Accepts left/right PCM sample pairs through a valid/ready handshake and serialises them as a standard Philips I2S stream (BCLK, LRCLK, SDATA) for the external DAC. Clocked by the audio clock out of the PLL/reset block; the sample source (synth voice mixer) sits upstream.

## Interface
Parameters:
- `WIDTH`, default 24: sample width in bits. Legal range 16..31.
- `BCLK_DIV`, default 2: `i_clk` cycles per BCLK half-period. Minimum 1.

Ports:
- `i_clk`, in, 1: audio clock. Single clock for the whole block.
- `i_rst`, in, 1: reset. Synchronous and active-high.
- `i_left`, in, `WIDTH`: left sample, two's complement.
- `i_right`, in, `WIDTH`: right sample, two's complement.
- `i_valid`, in, 1: sample pair valid.
- `o_ready`, out, 1: holding register empty; the pair is accepted when `i_valid && o_ready`.
- `o_bclk`, out, 1: I2S bit clock.
- `o_lrclk`, out, 1: word select. 0 = left, 1 = right.
- `o_sdata`, out, 1: serial data, MSB first.
- `o_underflow`, out, 1: one-cycle pulse when a frame starts with no pending sample.

## Operation
- **Divider.** Counts 0..`BCLK_DIV`-1. At the terminal count, `o_bclk` toggles and the divider wraps to 0.
- **Frame format.** A frame is 64 slots. A slot counter (0..63) advances on every BCLK falling edge, meaning any cycle where `o_bclk` toggles 1→0.
  - `o_lrclk` = 0 for slots 0..31 and 1 for slots 32..63.
  - Slot 0 carries 0. Slots 1..`WIDTH` carry left bits `WIDTH-1` down to 0. All remaining slots up to 31 carry 0.
  - Slots 32..63 carry the right channel in the same layout.
  - This gives the I2S one-BCLK MSB delay after each LRCLK edge.
- **Holding register.** One holding register holds one pending pair, with a full flag. `o_ready` = !full.
- **Frame load.** On the falling edge that enters slot 0:
  - If the holding register is full, its contents go into a 64-bit shift register and full clears.
  - If it is empty, the shift register is loaded with all zeros (silence) and `o_underflow` pulses for that cycle.
- **Simultaneous accept and load.** If an accept happens in the same cycle as a frame load, the load still sees the old (empty) state and underflows. The accepted pair is held for the next frame. There is no bypass path.
- **Shifting.** The shift register shifts one bit on each BCLK falling edge. `o_sdata` is its MSB.
- **Registered outputs.** All outputs are registered. `o_sdata` and `o_lrclk` change in the same `i_clk` cycle as the `o_bclk` falling edge, so they are stable at the rising edge.
- **Reset mid-frame.** Discards the frame and the pending pair, then restarts from the reset state.

## Timing
- **Reset values:**
  - `o_bclk`=0, `o_lrclk`=0, `o_sdata`=0, `o_ready`=1, `o_underflow`=0.
  - Divider = 0, slot counter = 63, holding register empty.
- **First edges after reset release:**
  - First BCLK rising edge: `BCLK_DIV` cycles after release.
  - First falling edge: 2·`BCLK_DIV` cycles after release. It enters slot 0 and performs the first frame load.
- **Frame period:** 128·`BCLK_DIV` `i_clk` cycles.
- **Accept to first bit:** a pair accepted at least one cycle before a frame load has its left MSB on `o_sdata` one BCLK period after that load (slot 1).
- **Ready timing:** `o_ready` rises in the cycle after the load that empties the holding register.

## Configuration
- **`I2S_TX_UNDERFLOW_CNT_EN` defined:**
  - Adds output `o_underflow_cnt`, 16 bits.
  - Increments on each `o_underflow` pulse and saturates at 0xFFFF.
  - Resets to 0 and is cleared only by `i_rst`.
- **Undefined:** the port and the counter are absent. `o_underflow` is unaffected.

## Structure
- **Shared package `audio_pkg`:**
  - `I2S_SLOTS` = 64 and `I2S_SLOT_BITS` = 32.
  - `stereo_sample_t` typedef: packed struct of left and right, width parameterised via a package parameter default of 24.
- **Sub-module `i2s_clk_div`:** divider plus BCLK generation. Outputs `o_bclk`, `o_fall` (one-cycle strobe on the falling edge) and `o_rise`. The top level holds the holding register, slot counter and shifter.

## Test plan
- **Single frame.** Reset, `BCLK_DIV`=2, `WIDTH`=24, one pair L=0xABCDEF, R=0x123456 accepted before the first load.
  - SDATA sampled on BCLK rising edges: slot 0 = 0, slots 1..24 = 0xABCDEF MSB-first, slots 25..31 = 0.
  - Slot 32 = 0, slots 33..56 = 0x123456.
  - LRCLK toggles at slots 0 and 32.
- **Underflow.** No input after reset → SDATA all 0 for the frame, `o_underflow` pulses once per frame.
  - With `I2S_TX_UNDERFLOW_CNT_EN`, `o_underflow_cnt` = 3 after 3 frames.
- **Backpressure.** `i_valid` held high with incrementing pairs → exactly one accept per frame (every 256 cycles). `o_ready` is low between load and the next cycle-after-load, and no pair is skipped or duplicated.
- **Simultaneous accept and load.** `i_valid` asserted on exactly the load cycle with the holding register empty → underflow pulse for that frame; the pair appears in the next frame.
- **Reset mid-frame.** Assert `i_rst` in slot 40 → outputs take reset values next cycle, `o_ready`=1, and the first load comes 4 cycles after release.
- **Minimum divider.** `BCLK_DIV`=1, full-scale L=0x7FFFFF, R=0x800000 → correct bits, frame period 128 cycles.
